// File: rtl/seg7_pkg.sv
// Shared types, segment table and width helpers for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

  // Active-high g..a patterns, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high segment decode; polarity is handled by the caller.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: one digit per slot with a leading blank gap,
// double-buffered frames swapped only at the wrap from the last digit to digit 0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES    = 27000,
  parameter int BLANK_CYCLES   = 270,
  parameter int NUM_DIGITS     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = clog_w(SLOT_CYCLES);
  localparam int IW = clog_w(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
  } frame_t;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  scan_state_t           state;
  scan_state_t           state_nxt;
  logic                  slot_end;
  logic                  frame_end;
  logic                  xfer;
  logic                  pend_full;
  frame_t                pend;
  frame_t                active;
  logic [3:0]            cur_hex;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] cur_hot;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign upd_ready = ~pend_full;
  assign xfer      = upd_valid && ~pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BLANK;
    else        state <= state_nxt;
  end

  // State mirrors cnt: DRIVE from BLANK_CYCLES up to the slot wrap.
  always_comb begin
    state_nxt = state;
    if (slot_end)                state_nxt = ST_BLANK;
    else if (cnt == BLANK_LAST)  state_nxt = ST_DRIVE;
  end

  always_comb begin
    cur_hex   = '0;
    cur_blank = 1'b1;
    cur_hot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_hex    = active.digits[4*i +: 4];
        cur_blank  = active.blank[i];
        cur_hot[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    seg_nxt = '0;
    an_nxt  = '0;
    if (state == ST_DRIVE && !cur_blank) begin
      seg_nxt = dec_seg;
      an_nxt  = cur_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ SEG_OFF;
      an         <= an_nxt ^ AN_OFF;
      frame_tick <= frame_end;
    end
  end

  // A boundary swap only happens with pending full, so it never races an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full     <= 1'b0;
      pend          <= '0;
      active.digits <= '0;
      active.blank  <= '1;
    end else if (xfer) begin
      pend      <= {upd_digits, upd_blank};
      pend_full <= 1'b1;
    end else if (frame_end && pend_full) begin
      active    <= pend;
      pend_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 8-cycle slots, 2-cycle blank, 4 digits, active-low.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .SLOT_CYCLES    (8),
    .BLANK_CYCLES   (2),
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_blank  (upd_blank),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-inverted glyphs as seen on the active-low segment bus.
  function automatic logic [6:0] hex_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Sample j (1..32) after a frame_tick shows cnt=(j-1)%8 of digit (j-1)/8.
  task automatic check_frame(input logic [15:0] dig, input logic [3:0] blk,
                             input logic exp_rdy, input int j0, input int j1);
    for (int j = j0; j <= j1; j++) begin
      int         d;
      int         c;
      logic       dark;
      logic [3:0] hot;
      logic [6:0] exp_seg;
      logic [3:0] exp_an;
      step();
      d       = (j - 1) / 8;
      c       = (j - 1) % 8;
      dark    = (c < 2) || blk[d];
      hot     = 4'b0001 << d;
      exp_seg = dark ? 7'h7F : hex_al(dig[4*d +: 4]);
      exp_an  = dark ? 4'hF : ~hot;
      chk($sformatf("seg j%0d", j), {25'd0, seg}, {25'd0, exp_seg});
      chk($sformatf("an j%0d", j), {28'd0, an}, {28'd0, exp_an});
      if (j < 32) begin
        chk($sformatf("tick j%0d", j), {31'd0, frame_tick}, 32'd0);
        chk($sformatf("ready j%0d", j), {31'd0, upd_ready}, {31'd0, exp_rdy});
      end else begin
        chk("tick wrap", {31'd0, frame_tick}, 32'd1);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    upd_valid  = 1'b0;
    upd_digits = 16'h0000;
    upd_blank  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst seg", {25'd0, seg}, 32'h7F);
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst ready", {31'd0, upd_ready}, 32'd1);
    chk("rst tick", {31'd0, frame_tick}, 32'd0);
    rst_n = 1'b1;

    // Dark frames after reset, tick every 32 cycles
    check_frame(16'h0000, 4'hF, 1'b1, 1, 32);
    check_frame(16'h0000, 4'hF, 1'b1, 1, 32);

    // Load 5C30; visible only after the next boundary
    upd_valid  = 1'b1;
    upd_digits = 16'h5C30;
    upd_blank  = 4'h0;
    step();
    chk("load accept", {31'd0, upd_ready}, 32'd0);
    chk("load seg j1", {25'd0, seg}, 32'h7F);
    upd_valid = 1'b0;
    check_frame(16'h0000, 4'hF, 1'b0, 2, 32);
    chk("load freed", {31'd0, upd_ready}, 32'd1);
    check_frame(16'h5C30, 4'h0, 1'b1, 1, 32);

    // Backpressure: A accepted at once, B held until the boundary frees pending
    upd_valid  = 1'b1;
    upd_digits = 16'h1234;
    upd_blank  = 4'h0;
    step();
    chk("bp A accept", {31'd0, upd_ready}, 32'd0);
    upd_digits = 16'hABCD;
    upd_blank  = 4'b0100;
    check_frame(16'h5C30, 4'h0, 1'b0, 2, 32);
    chk("bp freed", {31'd0, upd_ready}, 32'd1);
    check_frame(16'h1234, 4'h0, 1'b0, 1, 1);
    upd_valid = 1'b0;
    check_frame(16'h1234, 4'h0, 1'b0, 2, 32);
    chk("bp B freed", {31'd0, upd_ready}, 32'd1);

    // B carries a blank mask on digit 2; offer C in the boundary cycle
    check_frame(16'hABCD, 4'b0100, 1'b1, 1, 31);
    upd_valid  = 1'b1;
    upd_digits = 16'h6789;
    upd_blank  = 4'h0;
    check_frame(16'hABCD, 4'b0100, 1'b0, 32, 32);
    chk("coll accept", {31'd0, upd_ready}, 32'd0);
    upd_valid = 1'b0;
    check_frame(16'hABCD, 4'b0100, 1'b0, 1, 32);
    chk("coll freed", {31'd0, upd_ready}, 32'd1);

    // Async reset in the DRIVE part of digit 2
    check_frame(16'h6789, 4'h0, 1'b1, 1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst seg", {25'd0, seg}, 32'h7F);
    chk("arst an", {28'd0, an}, 32'hF);
    chk("arst tick", {31'd0, frame_tick}, 32'd0);
    chk("arst ready", {31'd0, upd_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    upd_valid  = 1'b1;
    upd_digits = 16'hF0E1;
    upd_blank  = 4'h0;
    check_frame(16'h0000, 4'hF, 1'b0, 1, 1);
    upd_valid = 1'b0;
    check_frame(16'h0000, 4'hF, 1'b0, 2, 32);
    chk("post rst freed", {31'd0, upd_ready}, 32'd1);
    check_frame(16'hF0E1, 4'h0, 1'b1, 1, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
